// File: rtl/exp_pipe.sv
// Streaming fixed-point e^x: Horner-form Taylor series, two register sub-stages per term, global stall.
// Define EXP_SATURATE_EN to build per-stage overflow clamping and the sticky exp_ovf_out flag.

module exp_step #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FRACTION   = 24,
    parameter logic [DATA_WIDTH-1:0] RECIP      = '0
) (
    input  logic                  clk,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] acc_in,
`ifdef EXP_SATURATE_EN
    input  logic                  ovf_in,
    output logic                  ovf_out,
`endif
    output logic [DATA_WIDTH-1:0] acc_out
);
    localparam int W2 = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(64'd1 << FRACTION);
    localparam logic [DATA_WIDTH-1:0] MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic signed [W2-1:0]   prod_a, prod_b;
    logic [DATA_WIDTH-1:0]  p_d, p_q, q_d, acc_d;
`ifdef EXP_SATURATE_EN
    logic signed [W2-1:0]   hi_a, hi_b;
    logic                   ovf_a_d, ovf_a_q, ovf_q, ovf_add, ovf_b_d;
`endif

    // Sub-stage a: p = x * acc, floor-truncated back to the input Q format.
    always_comb begin
        prod_a = W2'($signed(x)) * W2'($signed(acc_in));
        p_d    = DATA_WIDTH'(prod_a >>> FRACTION);
`ifdef EXP_SATURATE_EN
        hi_a    = prod_a >>> (FRACTION + DATA_WIDTH - 1);
        ovf_a_d = (hi_a != '0) && (hi_a != '1);
        if (ovf_a_d) p_d = MAX;
`endif
    end

    // Sub-stage b: acc = ONE + p * (1/k).
    always_comb begin
        prod_b = W2'($signed(p_q)) * W2'($signed(RECIP));
        q_d    = DATA_WIDTH'(prod_b >>> FRACTION);
`ifdef EXP_SATURATE_EN
        hi_b  = prod_b >>> (FRACTION + DATA_WIDTH - 1);
        ovf_q = (hi_b != '0) && (hi_b != '1);
        if (ovf_q) q_d = MAX;
`endif
        acc_d = ONE + q_d;
`ifdef EXP_SATURATE_EN
        // ONE is positive, so the add can only overflow upward.
        ovf_add = ~q_d[DATA_WIDTH-1] & acc_d[DATA_WIDTH-1];
        ovf_b_d = ovf_q | ovf_add;
        if (ovf_add) acc_d = MAX;
`endif
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            p_q     <= p_d;
            acc_out <= acc_d;
`ifdef EXP_SATURATE_EN
            ovf_a_q <= ovf_in | ovf_a_d;
            ovf_out <= ovf_a_q | ovf_b_d;
`endif
        end
    end
endmodule

module exp_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int FRACTION   = 24,
    parameter int TERMS      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exp_valid_in,
    output logic                  exp_ready_in,
    input  logic [DATA_WIDTH-1:0] exp_data_in,
    output logic                  exp_valid_out,
    input  logic                  exp_ready_out,
    output logic [DATA_WIDTH-1:0] exp_data_out,
    output logic                  exp_ovf_out
);
    localparam int STAGES = 2 * TERMS;
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(64'd1 << FRACTION);

    generate
        if (TERMS < 1 || TERMS > 12) begin : g_bad_terms
            $error("exp_pipe: TERMS must be in 1..12");
        end
    endgenerate

    function automatic logic [DATA_WIDTH-1:0] recip(input int k);
        longint num;
        num = (longint'(1) <<< FRACTION) + longint'(k / 2);
        return DATA_WIDTH'(num / longint'(k));
    endfunction

    logic [STAGES:0]       vld_pipe;
    logic                  advance;
    logic [DATA_WIDTH-1:0] x_pipe    [0:STAGES-2];
    logic [DATA_WIDTH-1:0] acc_chain [0:TERMS];

    assign advance       = ~vld_pipe[STAGES] | exp_ready_out;
    assign exp_ready_in  = advance;
    assign exp_valid_out = vld_pipe[STAGES];
    assign acc_chain[0]  = ONE;

    always_ff @(posedge clk) begin
        if (rst)          vld_pipe <= '0;
        else if (advance) vld_pipe <= {vld_pipe[STAGES-1:0], exp_valid_in};
    end

    // x rides alongside; the last step's b sub-stage no longer needs it.
    always_ff @(posedge clk) begin
        if (advance) begin
            x_pipe[0] <= exp_data_in;
            for (int j = 1; j <= STAGES - 2; j++) x_pipe[j] <= x_pipe[j-1];
        end
    end

`ifdef EXP_SATURATE_EN
    logic ovf_chain [0:TERMS];
    assign ovf_chain[0] = 1'b0;
`endif

    generate
        for (genvar i = 0; i < TERMS; i++) begin : g_step
            exp_step #(
                .DATA_WIDTH (DATA_WIDTH),
                .FRACTION   (FRACTION),
                .RECIP      (recip(TERMS - i))
            ) u_step (
                .clk     (clk),
                .advance (advance),
                .x       (x_pipe[2*i]),
                .acc_in  (acc_chain[i]),
`ifdef EXP_SATURATE_EN
                .ovf_in  (ovf_chain[i]),
                .ovf_out (ovf_chain[i+1]),
`endif
                .acc_out (acc_chain[i+1])
            );
        end
    endgenerate

`ifdef EXP_SATURATE_EN
    // e^x is never negative; a negative final acc is clamped and flagged.
    assign exp_data_out = acc_chain[TERMS][DATA_WIDTH-1] ? '0 : acc_chain[TERMS];
    assign exp_ovf_out  = vld_pipe[STAGES] & (ovf_chain[TERMS] | acc_chain[TERMS][DATA_WIDTH-1]);
`else
    assign exp_data_out = acc_chain[TERMS];
    assign exp_ovf_out  = 1'b0;
`endif
endmodule

// File: tb/tb_exp_pipe.sv
// Scoreboard bench for exp_pipe: accepted inputs push a Horner-model result, outputs pop and compare.
module tb_exp_pipe;
    localparam int DW  = 32;
    localparam int F   = 24;
    localparam int T   = 6;
    localparam int L   = 2 * T + 1;
    localparam int ONE = 1 << F;

    logic          clk = 1'b0;
    logic          rst;
    logic          exp_valid_in, exp_ready_in, exp_valid_out, exp_ready_out, exp_ovf_out;
    logic [DW-1:0] exp_data_in, exp_data_out;

    exp_pipe #(.DATA_WIDTH(DW), .FRACTION(F), .TERMS(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .exp_valid_in  (exp_valid_in),
        .exp_ready_in  (exp_ready_in),
        .exp_data_in   (exp_data_in),
        .exp_valid_out (exp_valid_out),
        .exp_ready_out (exp_ready_out),
        .exp_data_out  (exp_data_out),
        .exp_ovf_out   (exp_ovf_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int expv;
        bit expo;
        int refv;
        int tol;
        bit use_ref;
        int acc_cyc;
        int acc_stall;
    } item_t;

    item_t sb[$];
    int    n_chk = 0, n_err = 0, pop_cnt = 0, stall_cnt = 0;
    int    cur_ref = 0, cur_tol = 0;
    bit    cur_use_ref = 0;

    task automatic chk(input string tag, input longint act, input longint exp, input longint tol = 0);
        longint d;
        d = act - exp;
        if (d < 0) d = -d;
        n_chk++;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, act, act, exp, exp, tol);
        end
    endtask

    function automatic longint recip_tb(input int k);
        return ((longint'(1) << F) + longint'(k / 2)) / longint'(k);
    endfunction

    function automatic void model(input int x, output int r, output bit o);
        longint acc, p, q, s;
        int     p32, q32;
        acc = ONE;
        o   = 1'b0;
        for (int k = T; k >= 1; k--) begin
            p   = (longint'(x) * acc) >>> F;
            p32 = int'(p);
`ifdef EXP_SATURATE_EN
            if (p != longint'(p32)) begin p32 = 32'h7FFFFFFF; o = 1'b1; end
`endif
            q   = (longint'(p32) * recip_tb(k)) >>> F;
            q32 = int'(q);
`ifdef EXP_SATURATE_EN
            if (q != longint'(q32)) begin q32 = 32'h7FFFFFFF; o = 1'b1; end
`endif
            s = longint'(ONE) + longint'(q32);
`ifdef EXP_SATURATE_EN
            if (s > 64'sh7FFFFFFF) begin s = 64'sh7FFFFFFF; o = 1'b1; end
`endif
            acc = longint'(int'(s));
        end
`ifdef EXP_SATURATE_EN
        if (acc < 0) begin acc = 0; o = 1'b1; end
`endif
        r = int'(acc);
    endfunction

    // Monitor: stall hold checks, pops on handshake, pushes on accept.
    initial begin
        item_t       it;
        bit          prev_stall;
        logic [DW-1:0] prev_data;
        logic        prev_ovf;
        int          r;
        bit          o;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", exp_valid_out, 1);
                    chk("hold_data", $signed(exp_data_out), $signed(prev_data));
                    chk("hold_ovf", exp_ovf_out, prev_ovf);
                end
                prev_stall = exp_valid_out && !exp_ready_out;
                if (prev_stall) begin
                    stall_cnt++;
                    chk("ready_in_stall", exp_ready_in, 0);
                    prev_data = exp_data_out;
                    prev_ovf  = exp_ovf_out;
                end
                if (exp_valid_out && exp_ready_out) begin
                    chk("out_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        it = sb.pop_front();
                        chk("data_model", $signed(exp_data_out), it.expv);
                        chk("ovf", exp_ovf_out, it.expo);
                        chk("latency", cyc - it.acc_cyc, L + stall_cnt - it.acc_stall);
                        if (it.use_ref) chk("data_ref", $signed(exp_data_out), it.refv, it.tol);
                        pop_cnt++;
                    end
                end
                if (exp_valid_in && exp_ready_in) begin
                    model($signed(exp_data_in), r, o);
                    it.expv = r; it.expo = o;
                    it.refv = cur_ref; it.tol = cur_tol; it.use_ref = cur_use_ref;
                    it.acc_cyc = cyc; it.acc_stall = stall_cnt;
                    sb.push_back(it);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int x, input bit use_ref = 0, input int refv = 0, input int tol = 0);
        int w;
        w = 0;
        exp_valid_in = 1'b1;
        exp_data_in  = x;
        cur_use_ref  = use_ref;
        cur_ref      = refv;
        cur_tol      = tol;
        @(negedge clk);
        while (!exp_ready_in && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("send_timeout", w, 0);
        step();
        exp_valid_in = 1'b0;
        cur_use_ref  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain_left", sb.size(), 0);
        step();
    endtask

    function automatic int rand_x4();
        return int'($urandom_range(0, 8 << F)) - (4 << F);
    endfunction

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) send(rand_x4());
    endtask

    task automatic stall_at(input int base, input int k, input int n);
        int w;
        w = 0;
        while (pop_cnt < base + k && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) chk("stall_wait_timeout", w, 0);
        step();
        exp_ready_out = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        exp_ready_out = 1'b1;
    endtask

    initial begin
        int base;
        rst           = 1'b1;
        exp_valid_in  = 1'b0;
        exp_data_in   = '0;
        exp_ready_out = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", exp_valid_out, 0);
        chk("rst_ovf_out", exp_ovf_out, 0);
        chk("rst_ready_in", exp_ready_in, 1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_valid_out", exp_valid_out, 0);
        step();

        // Directed points
        send(0, 1, ONE, 0);
        send(32'h01000000, 1, 32'h02B7D27C, 16);
        send(32'hFF000000, 1, 6174955, 16);
        drain();

        // Back-to-back stream
        feed(100);
        drain();

        // Backpressure: 5-cycle stall once 7 results have left
        base = pop_cnt;
        fork
            feed(20);
            stall_at(base, 7, 5);
        join
        drain();
        chk("bp_count", pop_cnt - base, 20);

        // Saturation / wrap on a large input
`ifdef EXP_SATURATE_EN
        send(32'h0A000000, 1, 32'h7FFFFFFF, 0);
`else
        send(32'h0A000000);
`endif
        drain();

        // Reset with six items in flight
        feed(6);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready_in", exp_ready_in, 1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("quiet_valid", exp_valid_out, 0);
            chk("quiet_ovf", exp_ovf_out, 0);
        end
        step();
        send(32'h01000000, 1, 32'h02B7D27C, 16);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
